// File: rtl/memory_access.sv
// Memory stage: issues one load/store at a time on the data bus, aligns and
// extends load data, and hands a single registered record per instruction to writeback.
module memory_access #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_mem_op,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [XLEN-1:0] in_result,
  input  logic [REGW-1:0] in_dst,
  input  logic            in_wen,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [REGW-1:0] out_dst,
  output logic            out_wen,
  output logic [XLEN-1:0] out_mem_addr,
  output logic            out_misaligned,
  output logic            dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t          state;
  logic            kill;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_addr;
  logic [2:0]      cap_funct3;
  logic            cap_store;
  logic [REGW-1:0] cap_dst;
  logic            cap_wen;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic [7:0]      size_mask;
  logic [7:0]      strobe_next;
  logic [XLEN-1:0] store_shifted;
  logic [XLEN-1:0] load_shifted;
  logic [XLEN-1:0] load_ext;

  // Handshake: an instruction moves in when in_valid && in_ready && !flush.
  // in_ready depends on state only, so it never combinationally follows in_valid.
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign is_mem    = (in_mem_op == OP_LOAD) || (in_mem_op == OP_STORE);
  assign dbg_state = (state == BUSY);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (in_funct3[1:0])
      2'd0: begin misaligned = 1'b0;          size_mask = 8'h01; end
      2'd1: begin misaligned = in_addr[0];    size_mask = 8'h03; end
      2'd2: begin misaligned = |in_addr[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |in_addr[2:0]; size_mask = 8'hFF; end
    endcase
    strobe_next   = size_mask << in_addr[2:0];
    store_shifted = in_store_data << {in_addr[2:0], 3'b000};
  end

  // Response word is 64-bit aligned: move the addressed lane down, then extend.
  always_comb begin
    load_shifted = dresp_data >> {cap_addr[2:0], 3'b000};
    load_ext     = load_shifted;
    case (cap_funct3[1:0])
      2'd0: load_ext = cap_funct3[2] ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                                     : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_ext = cap_funct3[2] ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                                     : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_ext = cap_funct3[2] ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                                     : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      kill           <= 1'b0;
      cap_pc         <= '0;
      cap_addr       <= '0;
      cap_funct3     <= '0;
      cap_store      <= 1'b0;
      cap_dst        <= '0;
      cap_wen        <= 1'b0;
      dreq_valid     <= 1'b0;
      dreq_addr      <= '0;
      dreq_size      <= '0;
      dreq_strobe    <= '0;
      dreq_data      <= '0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_result     <= '0;
      out_dst        <= '0;
      out_wen        <= 1'b0;
      out_mem_addr   <= '0;
      out_misaligned <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem || misaligned) begin
              // Non-memory ops and misaligned accesses retire without the bus.
              out_valid      <= 1'b1;
              out_pc         <= in_pc;
              out_result     <= in_result;
              out_dst        <= in_dst;
              out_wen        <= is_mem ? 1'b0 : in_wen;
              out_mem_addr   <= in_addr;
              out_misaligned <= is_mem;
            end else begin
              state       <= BUSY;
              kill        <= 1'b0;
              cap_pc      <= in_pc;
              cap_addr    <= in_addr;
              cap_funct3  <= in_funct3;
              cap_store   <= (in_mem_op == OP_STORE);
              cap_dst     <= in_dst;
              cap_wen     <= in_wen;
              dreq_valid  <= 1'b1;
              dreq_addr   <= in_addr;
              dreq_size   <= {1'b0, in_funct3[1:0]};
              dreq_strobe <= (in_mem_op == OP_STORE) ? strobe_next : 8'h00;
              dreq_data   <= (in_mem_op == OP_STORE) ? store_shifted : '0;
            end
          end
        end
        BUSY: begin
          if (dresp_data_ok) begin
            state       <= IDLE;
            kill        <= 1'b0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            if (!(kill || flush)) begin
              out_valid      <= 1'b1;
              out_pc         <= cap_pc;
              out_result     <= cap_store ? '0 : load_ext;
              out_dst        <= cap_dst;
              out_wen        <= cap_store ? 1'b0 : cap_wen;
              out_mem_addr   <= cap_addr;
              out_misaligned <= 1'b0;
            end
          end else if (flush) begin
            // The request cannot be withdrawn; remember to drop its result.
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: vector table plus hand-written
// multi-cycle sequences, writeback records checked through an expected queue.
module tb_memory_access;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [REGW-1:0] dst;
    logic            wen;
    logic [XLEN-1:0] mem_addr;
    logic            mis;
  } wb_t;
  localparam int WB_W = $bits(wb_t);

  typedef struct {
    logic [1:0]      op;
    logic [2:0]      f3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] result;
    logic [REGW-1:0] dst;
    logic            wen;
    logic [XLEN-1:0] resp;
    int              waits;
    logic            bus;
    logic [XLEN-1:0] exp_result;
    logic            exp_wen;
    logic            exp_mis;
    logic [7:0]      exp_strobe;
    logic [XLEN-1:0] exp_data;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_addr, in_store_data, in_result;
  logic [1:0]      in_mem_op;
  logic [2:0]      in_funct3;
  logic [REGW-1:0] in_dst;
  logic            in_wen;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr, dreq_data;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;
  logic            out_valid, out_wen, out_misaligned, dbg_state;
  logic [XLEN-1:0] out_pc, out_result, out_mem_addr;
  logic [REGW-1:0] out_dst;

  logic [WB_W-1:0] exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  vec_t            vecs[14];

  memory_access #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_mem_op(in_mem_op), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_result(in_result), .in_dst(in_dst), .in_wen(in_wen),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result), .out_dst(out_dst),
    .out_wen(out_wen), .out_mem_addr(out_mem_addr), .out_misaligned(out_misaligned),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every writeback pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      wb_t act;
      act = '{pc: out_pc, result: out_result, dst: out_dst, wen: out_wen,
              mem_addr: out_mem_addr, mis: out_misaligned};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got record %h, required no writeback", act);
      end else begin
        logic [WB_W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL wb_record: got %h, required %h", act, e);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [XLEN-1:0] addr,
                              input logic [XLEN-1:0] sdata, input logic [XLEN-1:0] resp, input int waits,
                              input logic bus, input logic [XLEN-1:0] exp_result, input logic exp_wen,
                              input logic exp_mis, input logic [7:0] exp_strobe,
                              input logic [XLEN-1:0] exp_data);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.result = addr;
    v.dst = 5'd7; v.wen = 1'b1; v.resp = resp; v.waits = waits; v.bus = bus;
    v.exp_result = exp_result; v.exp_wen = exp_wen; v.exp_mis = exp_mis;
    v.exp_strobe = exp_strobe; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; in_mem_op = 2'd0; in_funct3 = 3'd0;
    in_pc = '0; in_addr = '0; in_store_data = '0; in_result = '0; in_dst = '0; in_wen = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input vec_t v);
    in_valid = 1'b1; in_pc = pc; in_mem_op = v.op; in_funct3 = v.f3; in_addr = v.addr;
    in_store_data = v.sdata; in_result = v.result; in_dst = v.dst; in_wen = v.wen;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 6;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Driver: one instruction through the stage, acting as the bus responder.
  task automatic run_vec(input string name, input logic [XLEN-1:0] pc, input vec_t v);
    wb_t e;
    e = '{pc: pc, result: v.exp_result, dst: v.dst, wen: v.exp_wen, mem_addr: v.addr, mis: v.exp_mis};
    drive(pc, v);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.bus) begin
      for (int c = 0; c <= v.waits; c++) begin
        check({name, "_dreq_valid"}, dreq_valid, 1);
        check({name, "_dreq_addr"}, dreq_addr, v.addr);
        check({name, "_dreq_size"}, dreq_size, {61'd0, v.f3[1:0]});
        check({name, "_dreq_strobe"}, dreq_strobe, v.exp_strobe);
        check({name, "_dreq_data"}, dreq_data, v.exp_data);
        check({name, "_in_ready_busy"}, in_ready, 0);
        check({name, "_early_valid"}, out_valid, 0);
        dresp_data_ok = (c == v.waits);
        dresp_data = (c == v.waits) ? v.resp : {$urandom(), $urandom()};
        @(negedge clk);
      end
      dresp_data_ok = 1'b0;
      check({name, "_dreq_drop"}, dreq_valid, 0);
    end else begin
      check({name, "_no_dreq"}, dreq_valid, 0);
    end
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_in_ready"}, in_ready, 1);
    drain({name, "_drain"});
  endtask

  initial begin
    vec_t ld;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table
    vecs[0]  = mk(2'd1, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 3, 1,
                  64'hFFFF_FFFF_FFFF_FF80, 1, 0, 8'h00, 64'h0);
    vecs[1]  = mk(2'd1, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 3, 1,
                  64'h80, 1, 0, 8'h00, 64'h0);
    vecs[2]  = mk(2'd2, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 1,
                  64'h0, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000);
    vecs[3]  = mk(2'd1, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 0, 64'h3002, 0, 1, 8'h00, 64'h0);
    vecs[4]  = mk(2'd1, 3'b011, 64'h4008, 64'h0, 64'h1122_3344_5566_7788, $urandom_range(0, 3), 1,
                  64'h1122_3344_5566_7788, 1, 0, 8'h00, 64'h0);
    vecs[5]  = mk(2'd1, 3'b001, 64'h4002, 64'h0, 64'h0000_0000_8001_0000, $urandom_range(0, 3), 1,
                  64'hFFFF_FFFF_FFFF_8001, 1, 0, 8'h00, 64'h0);
    vecs[6]  = mk(2'd1, 3'b110, 64'h4004, 64'h0, 64'hDEAD_BEEF_0000_0000, $urandom_range(0, 3), 1,
                  64'h0000_0000_DEAD_BEEF, 1, 0, 8'h00, 64'h0);
    vecs[7]  = mk(2'd1, 3'b010, 64'h4004, 64'h0, 64'hDEAD_BEEF_0000_0000, $urandom_range(0, 3), 1,
                  64'hFFFF_FFFF_DEAD_BEEF, 1, 0, 8'h00, 64'h0);
    vecs[8]  = mk(2'd2, 3'b000, 64'h5005, 64'h1234, 64'h0, $urandom_range(0, 3), 1,
                  64'h0, 0, 0, 8'h20, 64'h0012_3400_0000_0000);
    vecs[9]  = mk(2'd2, 3'b011, 64'h6000, 64'hCAFE_BABE_1234_5678, 64'h0, $urandom_range(0, 3), 1,
                  64'h0, 0, 0, 8'hFF, 64'hCAFE_BABE_1234_5678);
    vecs[10] = mk(2'd2, 3'b010, 64'h6004, 64'h89AB_CDEF, 64'h0, $urandom_range(0, 3), 1,
                  64'h0, 0, 0, 8'hF0, 64'h89AB_CDEF_0000_0000);
    vecs[11] = mk(2'd3, 3'b011, 64'h77, 64'h0, 64'h0, 0, 0, 64'h77, 1, 0, 8'h00, 64'h0);
    vecs[12] = mk(2'd2, 3'b001, 64'h2007, 64'h55, 64'h0, 0, 0, 64'h2007, 0, 1, 8'h00, 64'h0);
    vecs[13] = mk(2'd1, 3'b011, 64'h4004, 64'h0, 64'h0, 0, 0, 64'h4004, 0, 1, 8'h00, 64'h0);
    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), 64'h100 + 64'(i * 4), vecs[i]);

    // Back-to-back non-memory ops
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      wb_t e;
      v = mk(2'd0, 3'b000, 64'h900 + 64'(i), 64'h0, 64'h0, 0, 0, 64'(i + 1), 1, 0, 8'h00, 64'h0);
      v.result = 64'(i + 1);
      v.dst = 5'(i + 3);
      e = '{pc: 64'h800 + 64'(i), result: 64'(i + 1), dst: 5'(i + 3), wen: 1'b1,
            mem_addr: 64'h900 + 64'(i), mis: 1'b0};
      drive(64'h800 + 64'(i), v);
      exp_q.push_back(e);
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", out_result, 64'(i + 1));
      check("b2b_no_dreq", dreq_valid, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_end_valid", out_valid, 0);
    drain("b2b_drain");

    // Flush in IDLE: nothing is accepted
    drive(64'hA00, vecs[11]);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_valid", out_valid, 0);
    check("flush_idle_dreq", dreq_valid, 0);

    // Flush mid-BUSY, data_ok two cycles later
    ld = mk(2'd1, 3'b011, 64'h7000, 64'h0, 64'h0, 0, 1, 64'h0, 1, 0, 8'h00, 64'h0);
    drive(64'hB00, ld);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("kill_dreq_valid", dreq_valid, 1);
      check("kill_dreq_addr", dreq_addr, 64'h7000);
      check("kill_dreq_size", dreq_size, 3);
      check("kill_in_ready", in_ready, 0);
      check("kill_out_valid", out_valid, 0);
      flush = (c == 1);
      dresp_data_ok = (c == 3);
      dresp_data = 64'h1234;
      @(negedge clk);
    end
    flush = 1'b0; dresp_data_ok = 1'b0;
    check("kill_done_valid", out_valid, 0);
    check("kill_done_ready", in_ready, 1);
    check("kill_done_dreq", dreq_valid, 0);
    run_vec("after_kill", 64'hB10, vecs[4]);

    // Flush on the same cycle as data_ok
    drive(64'hC00, ld);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1; dresp_data_ok = 1'b1;
    @(negedge clk);
    flush = 1'b0; dresp_data_ok = 1'b0;
    check("flush_ok_valid", out_valid, 0);
    check("flush_ok_ready", in_ready, 1);
    run_vec("after_flush_ok", 64'hC10, vecs[0]);

    // Reset during BUSY
    drive(64'hD00, ld);
    @(negedge clk);
    in_valid = 1'b0;
    check("rbusy_state", dbg_state, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rbusy_dreq_valid", dreq_valid, 0);
    check("rbusy_dreq_addr", dreq_addr, 0);
    check("rbusy_state_idle", dbg_state, 0);
    check("rbusy_in_ready", in_ready, 1);
    check("rbusy_out_valid", out_valid, 0);
    check("rbusy_out_pc", out_pc, 0);
    check("rbusy_out_result", out_result, 0);
    check("rbusy_out_dst", out_dst, 0);
    check("rbusy_out_wen", out_wen, 0);
    check("rbusy_out_mem_addr", out_mem_addr, 0);
    check("rbusy_out_mis", out_misaligned, 0);
    reset = 1'b0;
    @(negedge clk);
    run_vec("after_reset", 64'hD10, vecs[2]);

    drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the in-order pipeline. Sits between execute and writeback.
- Issues load/store requests on the data bus and holds them until the bus responds.
- Aligns and extends load data, then hands one registered result per instruction to writeback, which consumes it unconditionally.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 64, data/address width
- REGW, 5, destination register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  kill the current/incoming instruction (branch/exception redirect)
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_mem_op  in  2  0=none, 1=load, 2=store, 3=reserved (treated as none)
- in_funct3  in  3  bits[1:0] size (0=B,1=H,2=W,3=D); bit2=1 means zero-extend (loads only)
- in_addr  in  XLEN  effective address (equals ALU result)
- in_store_data  in  XLEN  rs2 value, low-aligned
- in_result  in  XLEN  ALU result
- in_dst  in  REGW  destination register
- in_wen  in  1  instruction writes a register
- dreq_valid  out  1  bus request valid
- dreq_addr  out  XLEN  request address
- dreq_size  out  3  0..3 = 1/2/4/8 bytes
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  XLEN  store data, lane-shifted
- dresp_data_ok  in  1  response valid this cycle
- dresp_data  in  XLEN  read data, 64-bit aligned word
- out_valid  out  1  writeback record valid (one-cycle pulse per instruction)
- out_pc  out  XLEN  PC
- out_result  out  XLEN  final value
- out_dst  out  REGW  destination
- out_wen  out  1  register write enable
- out_mem_addr  out  XLEN  accessed address
- out_misaligned  out  1  misaligned-access flag

Behaviour:
- Reset (sync, active-high): state IDLE; all out_* = 0; dreq_valid=0; dreq_* = 0; kill flag cleared. A reset during BUSY abandons the transaction; the bus is reset on the same edge.
- States: IDLE, BUSY.
- in_ready = (state==IDLE). An instruction is accepted when in_valid && in_ready && !flush.
- IDLE, accepted non-memory op: next edge out_valid=1, out_result=in_result, out_wen=in_wen, other fields copied. Latency 1. Back-to-back every cycle is allowed.
- IDLE, accepted memory op, address misaligned (addr mod size != 0): no bus request. Next edge out_valid=1, out_misaligned=1, out_wen=0.
- IDLE, accepted aligned memory op: capture all fields and go to BUSY. From the next cycle drive:
  - dreq_valid=1
  - dreq_addr=addr
  - dreq_size=funct3[1:0]
  - store: dreq_strobe=((1<<2^size)-1)<<addr[2:0]; dreq_data=store_data<<(8*addr[2:0])
- BUSY: dreq_* held stable every cycle until dresp_data_ok=1. On that cycle:
  - next edge: state=IDLE, dreq_valid=0, out_valid=1 (unless killed).
  - load: out_result = sign/zero-extend of (dresp_data>>(8*addr[2:0])) truncated to size.
  - store: out_result=0, out_wen=0.
- Load latency = 1 (issue) + N cycles until data_ok + 1 (register). data_ok in the first BUSY cycle gives out_valid 2 cycles after acceptance.
- out_valid=0 in every cycle with no completion; the other out_* hold their last value.
- flush in IDLE: nothing accepted, out_valid=0 next cycle.
- flush in BUSY: set kill. The request is still held until data_ok (the bus protocol forbids withdrawal). Completion then produces out_valid=0, kill clears, state returns to IDLE.
- flush coinciding with data_ok: the instruction is killed (out_valid=0).
- No new acceptance in the cycle data_ok arrives (in_ready=0 in BUSY). The next instruction is accepted the following cycle.

Test Plan:
- Non-memory ops on 3 consecutive cycles (results 1,2,3) -> out_valid high 3 consecutive cycles with out_result 1,2,3; dreq_valid never asserted.
- Load byte signed at addr 0x1003; dresp_data=0x0000_0000_80FF_0000 after 3 wait cycles -> dreq_valid held 4 cycles, in_ready=0 throughout, out_result=0xFFFF_FFFF_FFFF_FF80; lbu -> 0x80.
- Store half at 0x2006, data 0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_size=1; on data_ok, out_valid=1 with out_wen=0.
- Load word at 0x3002 -> no dreq_valid; next cycle out_valid=1, out_misaligned=1, out_wen=0.
- Load issued, flush asserted mid-BUSY, data_ok 2 cycles later -> request held stable until data_ok, out_valid stays 0, in_ready returns to 1 the cycle after data_ok.
- Reset asserted during BUSY -> next cycle dreq_valid=0, state IDLE, all out_* = 0, in_ready=1.
